truth_table_scanner: RTL and testbench

- Sequential driver/capture engine for a 4-input combinational function block: the opposite end of that block's A/B/C/D -> Y interface.
- On start, it steps A,B,C,D through all 16 minterms, waits a settle time, samples Y, and assembles a 16-bit truth table.
- Optionally compares the table against an expected table and reports mismatch statistics.
- Used for on-chip self-check of the combinational function blocks in this codebase.

---
 rtl/truth_table_scanner_pkg.sv | 15 +
 rtl/truth_table_scanner_if.sv | 32 +++
 rtl/truth_table_scanner_settle_timer.sv | 41 ++++
 rtl/truth_table_scanner.sv | 136 +++++++++++++
 tb/tb_truth_table_scanner.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_scanner_pkg.sv
// ---------------------------------------------------------------------------
// scan_pkg
// Shared types and sizes for the truth-table scanner.
//   scan_state_t : IDLE -> DRIVE -> SAMPLE -> (DRIVE ... | DONE) -> IDLE
//   MINTERMS     : number of input combinations of a 4-input function
//   IDX_W        : width of a minterm index
//   CNT_W        : width of the mismatch counter (must hold 0..16)
// ---------------------------------------------------------------------------
package scan_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} scan_state_t;

    localparam int MINTERMS = 16;
    localparam int IDX_W    = 4;
    localparam int CNT_W    = 5;
endpackage

// File: rtl/truth_table_scanner_if.sv
// ---------------------------------------------------------------------------
// truth_table_scanner_if
// Host-side control/result bundle of the truth-table scanner.
//   start, check_en, expected        : host -> scanner request
//   busy, done                       : scanner -> host status
//   table_o, mismatch, mismatch_cnt,
//   first_bad                        : scanner -> host results
// slave modport is the scanner side, master modport is the host side.
// ---------------------------------------------------------------------------
interface truth_table_scanner_if;
    import scan_pkg::*;

    logic                start;
    logic                check_en;
    logic [MINTERMS-1:0] expected;
    logic                busy;
    logic                done;
    logic [MINTERMS-1:0] table_o;
    logic                mismatch;
    logic [CNT_W-1:0]    mismatch_cnt;
    logic [IDX_W-1:0]    first_bad;

    modport slave (
        input  start, check_en, expected,
        output busy, done, table_o, mismatch, mismatch_cnt, first_bad
    );

    modport master (
        output start, check_en, expected,
        input  busy, done, table_o, mismatch, mismatch_cnt, first_bad
    );
endinterface

// File: rtl/truth_table_scanner_settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer
// Down-counter that measures how long a minterm has been driven.
//   clk, rst : clock, async active-high reset
//   load     : restart the settle interval (next cycle is its first cycle)
//   en       : count down while the minterm is being driven
//   expired  : current cycle is the last cycle of the settle interval
// ---------------------------------------------------------------------------
module settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    logic [3:0] count_q;
    logic [3:0] count_d;

    // Loading SETTLE-1 makes the interval exactly SETTLE cycles long,
    // counting the cycle in which the count reaches zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = 4'(SETTLE - 1);
        end else if (en && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == 4'd0);
endmodule

// File: rtl/truth_table_scanner.sv
// ---------------------------------------------------------------------------
// truth_table_scanner
// Drives all 16 minterms into a 4-input combinational block, samples its
// response after a settle time and assembles the truth table, optionally
// comparing it against an expected table.
//   clk, rst   : clock, async active-high reset
//   host       : control/result bundle (slave side)
//   A,B,C,D    : minterm drive, A is the MSB
//   Y          : response of the function under test
// ---------------------------------------------------------------------------
module truth_table_scanner
    import scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    truth_table_scanner_if.slave   host,
    output logic                   A,
    output logic                   B,
    output logic                   C,
    output logic                   D,
    input  logic                   Y
);
    scan_state_t         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [MINTERMS-1:0] expected_q, expected_d;
    logic                check_q, check_d;
    logic [MINTERMS-1:0] table_q, table_d;
    logic                mismatch_q, mismatch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    first_bad_q, first_bad_d;

    logic timer_load;
    logic timer_expired;
    logic last_idx;

    assign last_idx = (idx_q == IDX_W'(MINTERMS - 1));

    // Restart the settle interval whenever a minterm is about to be driven.
    assign timer_load = ((state_q == IDLE) && host.start) ||
                        ((state_q == SAMPLE) && !last_idx);

    settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .en      (state_q == DRIVE),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (host.start) state_d = DRIVE;
            DRIVE:   if (timer_expired) state_d = SAMPLE;
            SAMPLE:  state_d = last_idx ? DONE : DRIVE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o_block: begin
            host.busy = (state_q == DRIVE) || (state_q == SAMPLE);
            host.done = (state_q == DONE);
            {A, B, C, D} = host.busy ? idx_q : 4'd0;
        end
    end

    // Request latching, sampling and incremental mismatch accounting.
    // The first mismatch is recognised by the counter still being zero.
    always_comb begin
        idx_d       = idx_q;
        expected_d  = expected_q;
        check_d     = check_q;
        table_d     = table_q;
        mismatch_d  = mismatch_q;
        cnt_d       = cnt_q;
        first_bad_d = first_bad_q;
        if ((state_q == IDLE) && host.start) begin
            expected_d  = host.expected;
            check_d     = host.check_en;
            table_d     = '0;
            mismatch_d  = 1'b0;
            cnt_d       = '0;
            first_bad_d = '0;
            idx_d       = '0;
        end else if (state_q == SAMPLE) begin
            table_d[idx_q] = Y;
            if (check_q && (Y != expected_q[idx_q])) begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == '0) begin
                    first_bad_d = idx_q;
                    mismatch_d  = 1'b1;
                end
            end
            if (!last_idx) begin
                idx_d = idx_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            expected_q  <= '0;
            check_q     <= 1'b0;
            table_q     <= '0;
            mismatch_q  <= 1'b0;
            cnt_q       <= '0;
            first_bad_q <= '0;
        end else begin
            idx_q       <= idx_d;
            expected_q  <= expected_d;
            check_q     <= check_d;
            table_q     <= table_d;
            mismatch_q  <= mismatch_d;
            cnt_q       <= cnt_d;
            first_bad_q <= first_bad_d;
        end
    end

    assign host.table_o      = table_q;
    assign host.mismatch     = mismatch_q;
    assign host.mismatch_cnt = cnt_q;
    assign host.first_bad    = first_bad_q;
endmodule

// File: tb/tb_truth_table_scanner.sv
// ---------------------------------------------------------------------------
// tb_truth_table_scanner
// Directed bench for truth_table_scanner. Instance 1 uses SETTLE=1,
// instance 2 uses SETTLE=3. Y is produced by a model of the function
// under test or tied to a constant.
// ---------------------------------------------------------------------------
module tb_truth_table_scanner;
    logic clk;
    logic rst;
    logic a1, b1, c1, d1, y1;
    logic a2, b2, c2, d2, y2;
    int   y_mode;
    int   cmp_cnt;
    int   err_cnt;

    truth_table_scanner_if bus1 ();
    truth_table_scanner_if bus2 ();

    truth_table_scanner #(.SETTLE(1)) u_dut1 (
        .clk (clk), .rst (rst), .host (bus1),
        .A (a1), .B (b1), .C (c1), .D (d1), .Y (y1)
    );

    truth_table_scanner #(.SETTLE(3)) u_dut2 (
        .clk (clk), .rst (rst), .host (bus2),
        .A (a2), .B (b2), .C (c2), .D (d2), .Y (y2)
    );

    // y_mode: 0 = function model, 1 = stuck at 0, 2 = stuck at 1
    assign y1 = (y_mode == 1) ? 1'b0 : (y_mode == 2) ? 1'b1 :
                (~a1 | (~b1 & ~(c1 & d1)) | (b1 & d1));
    assign y2 = (y_mode == 1) ? 1'b0 : (y_mode == 2) ? 1'b1 :
                (~a2 | (~b2 & ~(c2 & d2)) | (b2 & d2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Runs one scan on instance 1 starting from a negedge, and returns after
    // the negedge following edge k+40 (or k+34 in back-to-back mode).
    task automatic scan1(input bit extra, input bit scramble, input bit b2b,
                         output int lat, output int walk_bad, output int pulses);
        logic [15:0] exp_save;
        logic        chk_save;
        lat      = -1;
        walk_bad = 0;
        pulses   = 0;
        exp_save = bus1.expected;
        chk_save = bus1.check_en;
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int n = 0; n <= 40; n++) begin
            if (n < 32) begin
                if (({a1, b1, c1, d1} !== 4'(n / 2)) || (bus1.busy !== 1'b1)) walk_bad++;
            end
            if (bus1.done === 1'b1) begin
                pulses++;
                if (lat < 0) lat = n;
            end
            if (extra) bus1.start = (n == 5) || (n == 20) || (n == 32);
            if (scramble && (n == 10)) begin
                bus1.expected = ~exp_save;
                bus1.check_en = ~chk_save;
            end
            if (b2b && (n == 33)) bus1.start = 1'b1;
            if (b2b && (n == 34)) begin
                bus1.start = 1'b0;
                break;
            end
            @(negedge clk);
        end
        bus1.expected = exp_save;
        bus1.check_en = chk_save;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus1.start = 1'b1;
        bus2.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp_cnt++; if ({a1, b1, c1, d1} !== 4'd0) begin err_cnt++; $display("[TB] FAIL reset_abcd: got %h expected 0", {a1, b1, c1, d1}); end
            cmp_cnt++; if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_busy_done: got %b%b expected 00", bus1.busy, bus1.done); end
            cmp_cnt++; if (bus1.table_o !== 16'h0) begin err_cnt++; $display("[TB] FAIL reset_table: got %h expected 0000", bus1.table_o); end
            cmp_cnt++; if ({bus1.mismatch, bus1.mismatch_cnt, bus1.first_bad} !== 10'd0) begin err_cnt++; $display("[TB] FAIL reset_results: got %b/%0d/%0d expected 0/0/0", bus1.mismatch, bus1.mismatch_cnt, bus1.first_bad); end
            cmp_cnt++; if (bus2.busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_busy2: got %b expected 0", bus2.busy); end
        end
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp_cnt++; if (bus1.busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL idle_after_reset: got busy=%b expected 0", bus1.busy); end
    endtask

    task automatic test_golden();
        int lat, wb, pc;
        y_mode = 0;
        bus1.expected = 16'hA7FF;
        bus1.check_en = 1'b1;
        scan1(1'b0, 1'b0, 1'b0, lat, wb, pc);
        cmp_cnt++; if (wb !== 0) begin err_cnt++; $display("[TB] FAIL golden_walk: got %0d bad cycles expected 0", wb); end
        cmp_cnt++; if (lat !== 32) begin err_cnt++; $display("[TB] FAIL golden_latency: got %0d expected 32", lat); end
        cmp_cnt++; if (pc !== 1) begin err_cnt++; $display("[TB] FAIL golden_pulses: got %0d expected 1", pc); end
        cmp_cnt++; if (bus1.table_o !== 16'hA7FF) begin err_cnt++; $display("[TB] FAIL golden_table: got %h expected a7ff", bus1.table_o); end
        cmp_cnt++; if (bus1.mismatch !== 1'b0) begin err_cnt++; $display("[TB] FAIL golden_mismatch: got %b expected 0", bus1.mismatch); end
        cmp_cnt++; if (bus1.mismatch_cnt !== 5'd0) begin err_cnt++; $display("[TB] FAIL golden_cnt: got %0d expected 0", bus1.mismatch_cnt); end
        cmp_cnt++; if (bus1.first_bad !== 4'd0) begin err_cnt++; $display("[TB] FAIL golden_first_bad: got %0d expected 0", bus1.first_bad); end
    endtask

    task automatic test_mismatch();
        int lat, wb, pc;
        y_mode = 0;
        bus1.expected = 16'h2FFF;
        bus1.check_en = 1'b1;
        scan1(1'b0, 1'b1, 1'b0, lat, wb, pc);
        cmp_cnt++; if (bus1.mismatch !== 1'b1) begin err_cnt++; $display("[TB] FAIL mm_flag: got %b expected 1", bus1.mismatch); end
        cmp_cnt++; if (bus1.mismatch_cnt !== 5'd2) begin err_cnt++; $display("[TB] FAIL mm_cnt: got %0d expected 2", bus1.mismatch_cnt); end
        cmp_cnt++; if (bus1.first_bad !== 4'd11) begin err_cnt++; $display("[TB] FAIL mm_first_bad: got %0d expected 11", bus1.first_bad); end
        cmp_cnt++; if (bus1.table_o !== 16'hA7FF) begin err_cnt++; $display("[TB] FAIL mm_table: got %h expected a7ff", bus1.table_o); end
        bus1.check_en = 1'b0;
        scan1(1'b0, 1'b1, 1'b0, lat, wb, pc);
        cmp_cnt++; if (bus1.mismatch !== 1'b0) begin err_cnt++; $display("[TB] FAIL nochk_flag: got %b expected 0", bus1.mismatch); end
        cmp_cnt++; if (bus1.mismatch_cnt !== 5'd0) begin err_cnt++; $display("[TB] FAIL nochk_cnt: got %0d expected 0", bus1.mismatch_cnt); end
        cmp_cnt++; if (bus1.first_bad !== 4'd0) begin err_cnt++; $display("[TB] FAIL nochk_first_bad: got %0d expected 0", bus1.first_bad); end
        cmp_cnt++; if (bus1.table_o !== 16'hA7FF) begin err_cnt++; $display("[TB] FAIL nochk_table: got %h expected a7ff", bus1.table_o); end
    endtask

    task automatic test_stuck();
        int lat, wb, pc;
        y_mode = 1;
        bus1.expected = 16'hFFFF;
        bus1.check_en = 1'b1;
        scan1(1'b0, 1'b0, 1'b0, lat, wb, pc);
        cmp_cnt++; if (bus1.table_o !== 16'h0000) begin err_cnt++; $display("[TB] FAIL sa0_table: got %h expected 0000", bus1.table_o); end
        cmp_cnt++; if (bus1.mismatch_cnt !== 5'd16) begin err_cnt++; $display("[TB] FAIL sa0_cnt: got %0d expected 16", bus1.mismatch_cnt); end
        cmp_cnt++; if (bus1.first_bad !== 4'd0) begin err_cnt++; $display("[TB] FAIL sa0_first_bad: got %0d expected 0", bus1.first_bad); end
        cmp_cnt++; if (bus1.mismatch !== 1'b1) begin err_cnt++; $display("[TB] FAIL sa0_flag: got %b expected 1", bus1.mismatch); end

        y_mode = 2;
        bus2.expected = 16'h0000;
        bus2.check_en = 1'b0;
        lat = -1;
        @(negedge clk);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int n = 0; n <= 80; n++) begin
            if ((bus2.done === 1'b1) && (lat < 0)) lat = n;
            @(negedge clk);
        end
        cmp_cnt++; if (lat !== 64) begin err_cnt++; $display("[TB] FAIL sa1_latency: got %0d expected 64", lat); end
        cmp_cnt++; if (bus2.table_o !== 16'hFFFF) begin err_cnt++; $display("[TB] FAIL sa1_table: got %h expected ffff", bus2.table_o); end
        cmp_cnt++; if (bus2.mismatch_cnt !== 5'd0) begin err_cnt++; $display("[TB] FAIL sa1_cnt: got %0d expected 0", bus2.mismatch_cnt); end
    endtask

    task automatic test_handshake();
        int lat, wb, pc;
        y_mode = 0;
        bus1.expected = 16'hA7FF;
        bus1.check_en = 1'b1;
        scan1(1'b1, 1'b0, 1'b0, lat, wb, pc);
        cmp_cnt++; if (pc !== 1) begin err_cnt++; $display("[TB] FAIL hs_pulses: got %0d expected 1", pc); end
        cmp_cnt++; if (lat !== 32) begin err_cnt++; $display("[TB] FAIL hs_latency: got %0d expected 32", lat); end
        cmp_cnt++; if (wb !== 0) begin err_cnt++; $display("[TB] FAIL hs_walk: got %0d bad cycles expected 0", wb); end
        cmp_cnt++; if (bus1.busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL hs_idle_after: got busy=%b expected 0", bus1.busy); end
        cmp_cnt++; if (bus1.table_o !== 16'hA7FF) begin err_cnt++; $display("[TB] FAIL hs_table: got %h expected a7ff", bus1.table_o); end
    endtask

    task automatic test_back_to_back();
        int lat, wb, pc, lat2;
        y_mode = 0;
        bus1.expected = 16'hA7FF;
        bus1.check_en = 1'b1;
        scan1(1'b0, 1'b0, 1'b1, lat, wb, pc);
        cmp_cnt++; if (pc !== 1) begin err_cnt++; $display("[TB] FAIL b2b_first_done: got %0d pulses expected 1", pc); end
        cmp_cnt++; if (bus1.busy !== 1'b1) begin err_cnt++; $display("[TB] FAIL b2b_restart: got busy=%b expected 1", bus1.busy); end
        cmp_cnt++; if (bus1.table_o !== 16'h0000) begin err_cnt++; $display("[TB] FAIL b2b_cleared: got %h expected 0000", bus1.table_o); end
        lat2 = -1;
        for (int n = 0; n <= 40; n++) begin
            if ((bus1.done === 1'b1) && (lat2 < 0)) lat2 = n;
            @(negedge clk);
        end
        cmp_cnt++; if (lat2 !== 32) begin err_cnt++; $display("[TB] FAIL b2b_latency: got %0d expected 32", lat2); end
        cmp_cnt++; if (bus1.table_o !== 16'hA7FF) begin err_cnt++; $display("[TB] FAIL b2b_table: got %h expected a7ff", bus1.table_o); end
    endtask

    task automatic test_reset_mid_scan();
        int lat, wb, pc, seen, dn;
        y_mode = 0;
        bus1.expected = 16'h0000;
        bus1.check_en = 1'b1;
        seen = 0;
        dn   = 0;
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if ({a1, b1, c1, d1} === 4'd7) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        cmp_cnt++; if (seen !== 1) begin err_cnt++; $display("[TB] FAIL mid_reach7: got %0d expected 1", seen); end
        rst = 1'b1;
        #1;
        cmp_cnt++; if ({a1, b1, c1, d1} !== 4'd0) begin err_cnt++; $display("[TB] FAIL mid_abcd: got %h expected 0", {a1, b1, c1, d1}); end
        cmp_cnt++; if (bus1.busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL mid_busy: got %b expected 0", bus1.busy); end
        cmp_cnt++; if (bus1.table_o !== 16'h0000) begin err_cnt++; $display("[TB] FAIL mid_table: got %h expected 0000", bus1.table_o); end
        cmp_cnt++; if ({bus1.mismatch, bus1.mismatch_cnt, bus1.first_bad} !== 10'd0) begin err_cnt++; $display("[TB] FAIL mid_results: got %b/%0d/%0d expected 0/0/0", bus1.mismatch, bus1.mismatch_cnt, bus1.first_bad); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus1.done === 1'b1) dn++;
        end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus1.done === 1'b1) dn++;
        end
        cmp_cnt++; if (dn !== 0) begin err_cnt++; $display("[TB] FAIL mid_no_done: got %0d pulses expected 0", dn); end
        bus1.expected = 16'hA7FF;
        scan1(1'b0, 1'b0, 1'b0, lat, wb, pc);
        cmp_cnt++; if (bus1.table_o !== 16'hA7FF) begin err_cnt++; $display("[TB] FAIL mid_rescan_table: got %h expected a7ff", bus1.table_o); end
        cmp_cnt++; if (lat !== 32) begin err_cnt++; $display("[TB] FAIL mid_rescan_latency: got %0d expected 32", lat); end
    endtask

    initial begin
        cmp_cnt       = 0;
        err_cnt       = 0;
        y_mode        = 0;
        rst           = 1'b1;
        bus1.start    = 1'b0;
        bus1.check_en = 1'b0;
        bus1.expected = 16'h0;
        bus2.start    = 1'b0;
        bus2.check_en = 1'b0;
        bus2.expected = 16'h0;

        test_reset();
        test_golden();
        test_mismatch();
        test_stuck();
        test_handshake();
        test_back_to_back();
        test_reset_mid_scan();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
